// File: rtl/sample_packer.sv
// sample_packer: packs PACK_COUNT narrow samples into one wide word with frame-last
// and valid-lane count, using a single output register with skid-free backpressure.
module sample_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int PACK_COUNT = 4
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [IN_WIDTH-1:0]                  s_data_in,
    input  logic                                 s_valid_in,
    input  logic                                 s_last_in,
    output logic                                 s_ready_out,
    output logic [IN_WIDTH*PACK_COUNT-1:0]       m_data_out,
    output logic                                 m_valid_out,
    output logic                                 m_last_out,
    output logic [$clog2(PACK_COUNT+1)-1:0]      m_count_out,
    input  logic                                 m_ready_in
);
    localparam int DW = IN_WIDTH * PACK_COUNT;
    localparam int LW = $clog2(PACK_COUNT);
    localparam int CW = $clog2(PACK_COUNT + 1);

    logic [LW-1:0] lane_q, lane_d;
    logic [DW-1:0] acc_q, acc_d, data_q, data_d, merged;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d, last_q, last_d, accept, done;

    assign s_ready_out = !valid_q || m_ready_in;
    assign m_data_out  = data_q;
    assign m_valid_out = valid_q;
    assign m_last_out  = last_q;
    assign m_count_out = count_q;

    // The completing sample goes straight into the output word; the accumulator restarts empty.
    always_comb begin
        accept  = s_valid_in && s_ready_out;
        merged  = acc_q | (DW'(s_data_in) << (lane_q * IN_WIDTH));
        done    = accept && (s_last_in || lane_q == LW'(PACK_COUNT - 1));
        lane_d  = done ? '0 : accept ? lane_q + LW'(1) : lane_q;
        acc_d   = done ? '0 : accept ? merged : acc_q;
        valid_d = done || (valid_q && !m_ready_in);
        data_d  = done ? merged : data_q;
        last_d  = done ? s_last_in : last_q;
        count_d = done ? CW'(lane_q) + CW'(1) : count_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lane_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            lane_q  <= lane_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: scoreboard bench for sample_packer (IN_WIDTH=8, PACK_COUNT=4);
// a packing model pushes expected words on accepted samples, the monitor pops on transfer.
module tb_sample_packer;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [7:0]  s_data_in = '0;
    logic        s_valid_in = 1'b0;
    logic        s_last_in = 1'b0;
    logic        s_ready_out;
    logic [31:0] m_data_out;
    logic        m_valid_out;
    logic        m_last_out;
    logic [2:0]  m_count_out;
    logic        m_ready_in = 1'b1;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  c;
        logic        l;
    } word_t;

    word_t       sb[$];
    logic [31:0] exp_acc = '0;
    int          exp_lane = 0;
    int          n_vec = 0;
    int          n_err = 0;

    sample_packer #(.IN_WIDTH(8), .PACK_COUNT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .s_data_in(s_data_in), .s_valid_in(s_valid_in), .s_last_in(s_last_in),
        .s_ready_out(s_ready_out),
        .m_data_out(m_data_out), .m_valid_out(m_valid_out), .m_last_out(m_last_out),
        .m_count_out(m_count_out), .m_ready_in(m_ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sampled mid-cycle: whatever holds here is what the next rising edge acts on.
    always @(negedge clk_in) begin
        word_t w;
        if (rst_in) begin
            sb.delete();
            exp_acc  = '0;
            exp_lane = 0;
        end else begin
            if (m_valid_out && m_ready_in) begin
                if (sb.size() == 0) chk("unexpected_word", m_data_out, 0);
                else begin
                    w = sb.pop_front();
                    chk("word_data", m_data_out, w.d);
                    chk("word_count", m_count_out, w.c);
                    chk("word_last", m_last_out, w.l);
                end
            end
            if (s_valid_in && s_ready_out) begin
                exp_acc[exp_lane*8 +: 8] = s_data_in;
                exp_lane++;
                if (s_last_in || exp_lane == 4) begin
                    w.d = exp_acc;
                    w.c = 3'(exp_lane);
                    w.l = s_last_in;
                    sb.push_back(w);
                    exp_acc  = '0;
                    exp_lane = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        logic ok;
        int   t;
        s_valid_in = 1'b1;
        s_data_in  = d;
        s_last_in  = l;
        t = 0;
        do begin
            @(negedge clk_in);
            ok = s_ready_out;
            @(posedge clk_in);
            #1;
            t++;
        end while (!ok && t < 50);
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        s_valid_in = 1'b0;
        s_last_in  = 1'b1;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
        s_last_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_valid", m_valid_out, 0);
        chk("rst_data", m_data_out, 0);
        chk("rst_count", m_count_out, 0);
        chk("rst_last", m_last_out, 0);
        chk("rst_ready", s_ready_out, 1);
        @(posedge clk_in);
        #1;

        // Full word, single-cycle valid pulse.
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        s_valid_in = 1'b0;
        @(negedge clk_in);
        chk("full_valid", m_valid_out, 1);
        chk("full_data", m_data_out, 32'h44332211);
        chk("full_count", m_count_out, 4);
        @(negedge clk_in);
        chk("full_pulse", m_valid_out, 0);
        idle(2);

        // Short frame, then next sample starts in lane 0.
        send(8'hA1, 0); send(8'hA2, 1);
        s_valid_in = 1'b0;
        @(negedge clk_in);
        chk("short_data", m_data_out, 32'h0000A2A1);
        chk("short_count", m_count_out, 2);
        chk("short_last", m_last_out, 1);
        idle(2);
        send(8'hB0, 1);
        idle(3);

        // Last on the fourth sample: exactly one word.
        send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 1);
        idle(4);
        chk("last4_no_extra", sb.size(), 0);

        // Stall the first word for 5 cycles under continuous input.
        m_ready_in = 1'b0;
        fork
            begin
                for (int i = 1; i <= 12; i++) send(8'(i), 0);
                s_valid_in = 1'b0;
            end
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk_in);
                    t++;
                end while (!m_valid_out && t < 50);
                chk("stall_wait", m_valid_out, 1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk_in);
                    chk("stall_hold", m_data_out, 32'h04030201);
                    chk("stall_ready", s_ready_out, 0);
                end
                @(posedge clk_in);
                #1;
                m_ready_in = 1'b1;
            end
        join
        idle(4);
        chk("stall_drained", sb.size(), 0);

        // Sustained throughput: valid every 4th cycle, never stalling the source.
        fork
            begin
                for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 0);
                s_valid_in = 1'b0;
            end
            begin
                for (int k = 1; k <= 17; k++) begin
                    @(negedge clk_in);
                    chk("tput_ready", s_ready_out, 1);
                    chk("tput_valid", m_valid_out, (k >= 5 && k % 4 == 1));
                end
            end
        join
        idle(3);

        // Reset mid-word discards the partial and the sample presented during reset.
        send(8'h55, 0); send(8'h66, 0);
        s_data_in  = 8'h77;
        s_last_in  = 1'b0;
        rst_in     = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in     = 1'b0;
        s_valid_in = 1'b0;
        @(negedge clk_in);
        chk("mid_rst_valid", m_valid_out, 0);
        chk("mid_rst_data", m_data_out, 0);
        chk("mid_rst_count", m_count_out, 0);
        chk("mid_rst_last", m_last_out, 0);
        @(posedge clk_in);
        #1;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        s_valid_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_data", m_data_out, 32'h04030201);
        chk("post_rst_count", m_count_out, 4);
        idle(4);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
